// File: rtl/digitron_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : digitron_pkg
//  Purpose  : Shared definitions for the digitron display path: arbiter FSM
//             state encoding, default 1 ms prescale and 7-seg digit patterns.
//  Revision : 1.0 - initial release
// ============================================================================
package digitron_pkg;

  // 50 MHz system clock -> 50000 cycles per millisecond
  localparam int DEFAULT_T1MS = 50000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg7_digit(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digitron_ms_tick.sv
`default_nettype none
// ============================================================================
//  Module   : digitron_ms_tick
//  Purpose  : Millisecond prescaler. Counts 0..T1MS-1 while enabled and
//             flags a one-cycle tick on the terminal count; sync clear.
//  Revision : 1.0 - initial release
// ============================================================================
module digitron_ms_tick
  import digitron_pkg::*;
#(
  parameter int T1MS = DEFAULT_T1MS
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int              PW       = (T1MS > 1) ? $clog2(T1MS) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(T1MS - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign tick_o = en_i && (pre_q == PRE_LAST);

  // Next prescaler value: clear wins, otherwise count and return to 0 on tick
  always_comb begin
    pre_d = pre_q;
    if (clr_i) begin
      pre_d = '0;
    end else if (en_i) begin
      pre_d = tick_o ? '0 : pre_q + 1'b1;
    end
  end

  // Prescaler register
  always_ff @(posedge CLK) begin
    if (RST) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule
`default_nettype wire

// File: rtl/digitron_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : digitron_display_arbiter
//  Purpose  : Round-robin arbiter sharing one 7-seg number display among
//             NUM_REQ sources; each granted value is held for HOLD_MS ms.
//  Config   : DIGITRON_SRC_ID_EN - adds Disp_Src (granted source index).
//  Revision : 1.0 - initial release
// ============================================================================
module digitron_display_arbiter
  import digitron_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int T1MS    = DEFAULT_T1MS,
  parameter int HOLD_MS = 500
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     Req_Valid,
  input  logic [NUM_REQ*8-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]     Req_Ack,
  output logic [NUM_REQ-1:0]     Grant,
  output logic [7:0]             Disp_Data,
  output logic                   Disp_Busy
`ifdef DIGITRON_SRC_ID_EN
  ,
  output logic [$clog2(NUM_REQ)-1:0] Disp_Src
`endif
);

  localparam int            IW        = $clog2(NUM_REQ);
  localparam int            MW        = $clog2(HOLD_MS + 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);
  localparam logic [MW-1:0] MS_LAST   = MW'(HOLD_MS - 1);

  // First valid index after 'last', wrapping modulo NUM_REQ
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [IW-1:0]      last);
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (!found && valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  state_t               state_q, state_d;
  // The winner index doubles as the round-robin pointer: idx == last always
  logic [IW-1:0]        last_q,  last_d;
  logic [MW-1:0]        ms_q,    ms_d;
  logic [7:0]           data_q,  data_d;
  logic [NUM_REQ-1:0]   ack_q,   ack_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q,  busy_d;
  logic                 tick;

  digitron_ms_tick #(
    .T1MS (T1MS)
  ) u_ms_tick (
    .CLK    (CLK),
    .RST    (RST),
    .clr_i  (state_q == ST_LOAD),
    .en_i   (state_q == ST_HOLD),
    .tick_o (tick)
  );

  // Next-state and next-output logic; registers hold unless a state acts
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ms_d    = ms_q;
    data_d  = data_q;
    ack_d   = '0;
    grant_d = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|Req_Valid) begin
          last_d  = rr_pick(Req_Valid, last_q);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        data_d  = Req_Data[8*last_q +: 8];
        ack_d   = onehot(last_q);
        grant_d = onehot(last_q);
        ms_d    = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (tick) begin
          if (ms_q == MS_LAST) begin
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_INIT;
      ms_q    <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ms_q    <= ms_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign Req_Ack   = ack_q;
  assign Grant     = grant_q;
  assign Disp_Data = data_q;
  assign Disp_Busy = busy_q;

`ifdef DIGITRON_SRC_ID_EN
  logic [IW-1:0] src_q;

  // Source id follows Disp_Data: loaded in LOAD, held otherwise
  always_ff @(posedge CLK) begin
    if (RST)                    src_q <= '0;
    else if (state_q == ST_LOAD) src_q <= last_q;
  end

  assign Disp_Src = src_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_digitron_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digitron_display_arbiter
//  Purpose  : Directed self-checking bench, T1MS=4 / HOLD_MS=2 (period 10).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_digitron_display_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  Req_Valid = '0;
  logic [31:0] Req_Data  = '0;
  logic [3:0]  Req_Ack;
  logic [3:0]  Grant;
  logic [7:0]  Disp_Data;
  logic        Disp_Busy;
`ifdef DIGITRON_SRC_ID_EN
  logic [1:0]  Disp_Src;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  digitron_display_arbiter #(
    .NUM_REQ (4),
    .T1MS    (4),
    .HOLD_MS (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Req_Valid (Req_Valid),
    .Req_Data  (Req_Data),
    .Req_Ack   (Req_Ack),
    .Grant     (Grant),
    .Disp_Data (Disp_Data),
    .Disp_Busy (Disp_Busy)
`ifdef DIGITRON_SRC_ID_EN
    ,
    .Disp_Src  (Disp_Src)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance until an Ack pulse appears (bounded); caller checks the value
  task automatic wait_ack();
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (Req_Ack != 4'b0) break;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 25; i++) begin
      if (!Disp_Busy) break;
      step(1);
    end
    chk("wait_idle", 32'(Disp_Busy), 32'd0);
  endtask

  logic [7:0] exp_rr [4];
  int         n_ack;
  int         prev_c;
  int         busy_cnt;

  initial begin
    exp_rr = '{8'd10, 8'd20, 8'd30, 8'd40};

    // ---- Reset with random request activity ----
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Req_Valid = 4'($urandom);
      Req_Data  = $urandom;
      step(1);
      chk("rst_ack", 32'(Req_Ack), 32'd0);
    end
    chk("rst_data",  32'(Disp_Data), 32'd0);
    chk("rst_grant", 32'(Grant),     32'd0);
    chk("rst_busy",  32'(Disp_Busy), 32'd0);
    RST = 1'b0;
    Req_Valid = '0;
    Req_Data  = '0;
    step(1);
    chk("idle_busy", 32'(Disp_Busy), 32'd0);

    // ---- Single request, latency and busy length ----
    Req_Valid = 4'b0001;
    Req_Data[7:0] = 8'd123;
    step(1);
    chk("lat1_busy", 32'(Disp_Busy), 32'd1);
    chk("lat1_ack",  32'(Req_Ack),   32'd0);
    chk("lat1_data", 32'(Disp_Data), 32'd0);
    step(1);
    chk("lat2_ack",   32'(Req_Ack),   32'b0001);
    chk("lat2_data",  32'(Disp_Data), 32'd123);
    chk("lat2_grant", 32'(Grant),     32'b0001);
    Req_Valid = '0;
    busy_cnt = 2;
    step(1);
    chk("ack_pulse", 32'(Req_Ack), 32'd0);
    if (Disp_Busy) busy_cnt++;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (Disp_Busy) busy_cnt++;
    end
    chk("busy_len",   32'(busy_cnt),  32'd9);
    chk("end_grant",  32'(Grant),     32'd0);
    chk("data_holds", 32'(Disp_Data), 32'd123);

    // ---- All four held: round-robin from index 0 after reset ----
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    Req_Data  = {8'd40, 8'd30, 8'd20, 8'd10};
    Req_Valid = 4'b1111;
    n_ack  = 0;
    prev_c = 0;
    for (int c = 1; c <= 45; c++) begin
      step(1);
      if (Req_Ack != 4'b0) begin
        if (n_ack == 0) chk("rr_first_lat", 32'(c), 32'd2);
        else            chk("rr_period", 32'(c - prev_c), 32'd10);
        chk("rr_ack",  32'(Req_Ack),   32'(4'b0001 << (n_ack % 4)));
        chk("rr_data", 32'(Disp_Data), 32'(exp_rr[n_ack % 4]));
        prev_c = c;
        n_ack++;
      end
    end
    chk("rr_count", 32'(n_ack), 32'd5);
    Req_Valid = '0;
    wait_idle();

    // ---- After grant to 1, raise 3 and 0: expect 3 then 0 ----
    Req_Data  = '0;
    Req_Valid = 4'b0010;
    Req_Data[15:8] = 8'd55;
    wait_ack();
    chk("g1_ack",   32'(Req_Ack),   32'b0010);
    chk("g1_data",  32'(Disp_Data), 32'd55);
    chk("g1_grant", 32'(Grant),     32'b0010);
    Req_Valid = 4'b1001;
    Req_Data[31:24] = 8'd77;
    Req_Data[7:0]   = 8'd11;
    wait_ack();
    chk("g3_ack",  32'(Req_Ack),   32'b1000);
    chk("g3_data", 32'(Disp_Data), 32'd77);
    Req_Valid = 4'b0001;
    wait_ack();
    chk("g0_ack",  32'(Req_Ack),   32'b0001);
    chk("g0_data", 32'(Disp_Data), 32'd11);
    Req_Valid = '0;
    wait_idle();

    // ---- Grant to 2, then reset mid-HOLD ----
    Req_Valid = 4'b0100;
    Req_Data[23:16] = 8'd99;
    wait_ack();
    chk("g2_ack",  32'(Req_Ack),   32'b0100);
    chk("g2_data", 32'(Disp_Data), 32'd99);
`ifdef DIGITRON_SRC_ID_EN
    chk("g2_src",  32'(Disp_Src),  32'd2);
`endif
    Req_Valid = '0;
    step(3);
    chk("midhold_busy", 32'(Disp_Busy), 32'd1);
    RST = 1'b1;
    step(1);
    chk("mrst_data",  32'(Disp_Data), 32'd0);
    chk("mrst_grant", 32'(Grant),     32'd0);
    chk("mrst_busy",  32'(Disp_Busy), 32'd0);
    chk("mrst_ack",   32'(Req_Ack),   32'd0);
`ifdef DIGITRON_SRC_ID_EN
    chk("mrst_src",   32'(Disp_Src),  32'd0);
`endif
    RST = 1'b0;
    Req_Valid = 4'b0101;
    Req_Data[7:0] = 8'd5;
    wait_ack();
    chk("post_rst_ack",  32'(Req_Ack),   32'b0001);
    chk("post_rst_data", 32'(Disp_Data), 32'd5);
    Req_Valid = '0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
